// File: rtl/mips_defs.sv
// Shared definitions for the multiply/divide unit in the 5-stage MIPS pipeline.
// Holds the md_op encoding, the default latencies and a small helper that
// classifies the ops that occupy the unit for multiple cycles.
package mips_defs;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    localparam int MULT_CYCLES_DEFAULT = 5;
    localparam int DIV_CYCLES_DEFAULT  = 10;

    // True for the ops that compute a 64-bit result and hold the unit busy.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    // True for the two divide ops, which use the longer latency.
    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit result generator for MULT/MULTU/DIV/DIVU.
// Ports:
//   op        in  3   md_op code
//   a         in  32  rs operand (multiplicand / dividend)
//   b         in  32  rt operand (multiplier / divisor)
//   res_hi    out 32  upper product word or remainder
//   res_lo    out 32  lower product word or quotient
//   res_valid out 1   result should be written to HI/LO at completion
//                     (low for divide by zero and for non-arithmetic ops)
module md_calc
    import mips_defs::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        res_valid
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_zero;
    logic [31:0] b_safe;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // The divider never sees zero so the arithmetic stays well defined;
    // the zero case is suppressed through res_valid instead.
    assign div_zero = (b == 32'd0);
    assign b_safe   = div_zero ? 32'd1 : b;

    // Signed divide is done on magnitudes and the signs restored afterwards.
    // This truncates toward zero, gives the remainder the dividend's sign,
    // and makes 0x80000000 / -1 come out as quotient 0x80000000, remainder 0
    // because the magnitude 0x80000000 negates back onto itself.
    assign a_mag = a[31]      ? (~a + 32'd1)      : a;
    assign b_mag = b_safe[31] ? (~b_safe + 32'd1) : b_safe;
    assign q_mag = a_mag / b_mag;
    assign r_mag = a_mag % b_mag;
    assign q_s   = (a[31] ^ b_safe[31]) ? (~q_mag + 32'd1) : q_mag;
    assign r_s   = a[31] ? (~r_mag + 32'd1) : r_mag;

    assign q_u = a / b_safe;
    assign r_u = a % b_safe;

    always_comb begin
        res_hi    = 32'd0;
        res_lo    = 32'd0;
        res_valid = 1'b0;
        case (op)
            MD_MULT: begin
                {res_hi, res_lo} = prod_s;
                res_valid        = 1'b1;
            end
            MD_MULTU: begin
                {res_hi, res_lo} = prod_u;
                res_valid        = 1'b1;
            end
            MD_DIV: begin
                res_hi    = r_s;
                res_lo    = q_s;
                res_valid = !div_zero;
            end
            MD_DIVU: begin
                res_hi    = r_u;
                res_lo    = q_u;
                res_valid = !div_zero;
            end
            default: begin
                res_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with the HI/LO registers, sitting in the
// E stage. The result is computed up front and held in pending registers;
// a down-counter models the latency and HI/LO are written when it expires.
// Ports:
//   clk       in  1   system clock
//   reset     in  1   synchronous active-low reset
//   start     in  1   E-stage request, op sampled on this edge
//   md_op     in  3   operation code (mips_defs::md_op_e)
//   rs_val    in  32  rs operand / MTHI-MTLO data
//   rt_val    in  32  rt operand
//   d_md_use  in  1   D-stage instruction touches the md unit
//   busy      out 1   operation in flight
//   md_stall  out 1   combinational stall request for the pipeline
//   hi        out 32  architectural HI
//   lo        out 32  architectural LO
module md_unit
    import mips_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_md_use,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] count;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic             pend_valid;

    logic [31:0]      calc_hi;
    logic [31:0]      calc_lo;
    logic             calc_valid;
    logic             long_op;

    md_calc u_calc (
        .op        (md_op),
        .a         (rs_val),
        .b         (rt_val),
        .res_hi    (calc_hi),
        .res_lo    (calc_lo),
        .res_valid (calc_valid)
    );

    assign long_op  = is_long_op(md_op);
    assign busy     = (count != '0);
    assign md_stall = d_md_use & (busy | (start & long_op));

    // A start while busy is dropped entirely; the busy branch takes priority.
    // HI/LO are only written from the pending registers on the 1 -> 0 count
    // step, so a reset mid-operation discards the result for good.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count      <= '0;
            pend_hi    <= 32'd0;
            pend_lo    <= 32'd0;
            pend_valid <= 1'b0;
            hi         <= 32'd0;
            lo         <= 32'd0;
        end else if (busy) begin
            count <= count - CNT_W'(1);
            if ((count == CNT_W'(1)) && pend_valid) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end else if (start) begin
            if (long_op) begin
                pend_hi    <= calc_hi;
                pend_lo    <= calc_lo;
                pend_valid <= calc_valid;
                count      <= is_div_op(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else if (md_op == MD_MTHI) begin
                hi <= rs_val;
            end else if (md_op == MD_MTLO) begin
                lo <= rs_val;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit. Inputs are driven 1 time unit
// after the rising edge, outputs are checked shortly after that, away from
// the edge. Expected values are hand-computed constants.
module tb_md_unit;
    import mips_defs::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_md_use;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    md_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .d_md_use (d_md_use),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive all request inputs at once.
    task automatic applyStimulus(input logic s, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic use_d);
        start    = s;
        md_op    = op;
        rs_val   = a;
        rt_val   = b;
        d_md_use = use_d;
        #1;
    endtask

    // One comparison: count it, and report tag/observed/expected on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a long op with d_md_use held high, check busy/md_stall for every
    // busy cycle and the HI/LO result in the first idle cycle. Optionally
    // fire a second start (DIVU 100/7) during busy, which must be ignored.
    task automatic runLong(input string tag, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input int cycles, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input logic inject_second);
        applyStimulus(1'b1, op, a, b, 1'b1);
        checkOutput({tag, " idle_before"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, " stall_start"}, {31'd0, md_stall}, 32'd1);
        step();
        for (int i = 0; i < cycles; i++) begin
            if (inject_second && i == 1)
                applyStimulus(1'b1, MD_DIVU, 32'd100, 32'd7, 1'b1);
            else
                applyStimulus(1'b0, MD_NONE, 32'd0, 32'd0, 1'b1);
            checkOutput($sformatf("%s busy_c%0d", tag, i), {31'd0, busy}, 32'd1);
            checkOutput($sformatf("%s stall_c%0d", tag, i), {31'd0, md_stall}, 32'd1);
            step();
        end
        applyStimulus(1'b0, MD_NONE, 32'd0, 32'd0, 1'b1);
        checkOutput({tag, " busy_done"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, " stall_done"}, {31'd0, md_stall}, 32'd0);
        checkOutput({tag, " hi"}, hi, exp_hi);
        checkOutput({tag, " lo"}, lo, exp_lo);
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);

        // Reset, then idle outputs with and without a D-stage md instruction.
        step();
        checkOutput("reset hi", hi, 32'd0);
        checkOutput("reset lo", lo, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset stall_use0", {31'd0, md_stall}, 32'd0);
        applyStimulus(1'b0, MD_NONE, 32'd0, 32'd0, 1'b1);
        checkOutput("reset stall_use1", {31'd0, md_stall}, 32'd0);
        reset = 1'b1;
        step();

        // Multiplies: -1 * 2 signed, 0xFFFFFFFF * 2 unsigned.
        runLong("mult", MD_MULT, 32'hFFFFFFFF, 32'h00000002, 5,
                32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        runLong("multu", MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 5,
                32'h00000001, 32'hFFFFFFFE, 1'b0);

        // Divides: -7/2 -> q=-3 r=-1, 7/2 unsigned, and the overflow case.
        runLong("div", MD_DIV, 32'hFFFFFFF9, 32'h00000002, 10,
                32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        runLong("divu", MD_DIVU, 32'h00000007, 32'h00000002, 10,
                32'h00000001, 32'h00000003, 1'b0);
        runLong("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10,
                32'h00000000, 32'h80000000, 1'b0);

        // Stall handshake with a second start during busy; 16*16 = 0x100.
        runLong("stall2nd", MD_MULT, 32'h00000010, 32'h00000010, 5,
                32'h00000000, 32'h00000100, 1'b1);

        // MTHI / MTLO: single-edge writes, never busy, no stall.
        applyStimulus(1'b1, MD_MTHI, 32'h12345678, 32'd0, 1'b1);
        checkOutput("mthi stall", {31'd0, md_stall}, 32'd0);
        step();
        applyStimulus(1'b1, MD_MTLO, 32'h9ABCDEF0, 32'd0, 1'b0);
        checkOutput("mthi hi", hi, 32'h12345678);
        checkOutput("mthi busy", {31'd0, busy}, 32'd0);
        step();
        applyStimulus(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
        checkOutput("mtlo lo", lo, 32'h9ABCDEF0);
        checkOutput("mtlo hi_kept", hi, 32'h12345678);
        checkOutput("mtlo busy", {31'd0, busy}, 32'd0);

        // Undefined code 7 and MD_NONE with start: no effect.
        applyStimulus(1'b1, 3'd7, 32'hDEADBEEF, 32'h00000003, 1'b0);
        step();
        applyStimulus(1'b1, MD_NONE, 32'hCAFEF00D, 32'h00000005, 1'b0);
        step();
        applyStimulus(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
        checkOutput("undef busy", {31'd0, busy}, 32'd0);
        checkOutput("undef hi", hi, 32'h12345678);
        checkOutput("undef lo", lo, 32'h9ABCDEF0);

        // Divide by zero: full latency, HI/LO untouched.
        runLong("divzero", MD_DIV, 32'h00000005, 32'h00000000, 10,
                32'h12345678, 32'h9ABCDEF0, 1'b0);

        // Reset on cycle 3 of a DIVU 100/7: aborted, no late write.
        applyStimulus(1'b1, MD_DIVU, 32'd100, 32'd7, 1'b0);
        step();
        applyStimulus(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
        step();
        step();
        checkOutput("abort busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        step();
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort hi", hi, 32'd0);
        checkOutput("abort lo", lo, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) step();
        checkOutput("abort late_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort late_hi", hi, 32'd0);
        checkOutput("abort late_lo", lo, 32'd0);

        $display("[TB] directed sequence complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit for the 5-stage MIPS pipeline. It holds the HI/LO registers and sits in the E stage beside the ALU.
- It is the producer side of the stall handshake. It reports a busy window so the D stage is frozen while an md-class instruction in D would collide with an unfinished operation.
- It supplies HI/LO read data for MFHI/MFLO and accepts MTHI/MTLO writes.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for MULT/MULTU (must be >= 1).
- DIV_CYCLES, 10, number of busy cycles for DIV/DIVU (must be >= 1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  E-stage request; the op is sampled on the edge where start=1.
- md_op  in  3  operation code (encoding in Decomposition).
- rs_val  in  32  forwarded E-stage rs operand (dividend / multiplicand / MTHI/MTLO data).
- rt_val  in  32  forwarded E-stage rt operand (divisor / multiplier).
- d_md_use  in  1  D-stage instruction is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- busy  out  1  operation in flight.
- md_stall  out  1  combinational stall request, ORed into the pipeline stall.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset (reset=0 at an edge): hi=0, lo=0, count=0, busy=0, pending regs=0. Reset mid-operation aborts it; HI/LO do not receive the pending result.
- start is only honoured when busy=0. If start=1 while busy=1, it is ignored with no state change; the stall logic prevents this, and the bench checks it anyway.
- start with MULT/MULTU/DIV/DIVU:
  - The full 64-bit result is computed from rs_val/rt_val and latched into pend_hi/pend_lo.
  - count is loaded with MULT_CYCLES or DIV_CYCLES.
- busy = (count != 0). While busy, count decrements by 1 every edge.
- On the edge where count goes 1 -> 0, hi <= pend_hi and lo <= pend_lo.
- Result: busy is high for exactly N cycles after the start edge, and the new HI/LO become visible in the first cycle busy=0.
- MULT: signed 32x32 -> 64; hi = upper 32 bits, lo = lower 32 bits. MULTU: same, unsigned.
- DIV: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - Special case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (rt_val=0): busy still runs DIV_CYCLES, but HI/LO are left unchanged at completion.
- start with MTHI: hi <= rs_val on the sampling edge. start with MTLO: lo <= rs_val. Neither asserts busy.
- start with NONE, or with an undefined code 7: no effect.
- md_stall = d_md_use & (busy | (start & op is MULT/MULTU/DIV/DIVU)). It is purely combinational with no register.
- hi/lo are register outputs. MFHI/MFLO read them in E with no bypass of an in-flight result, because md_stall guarantees completion first.

Decomposition:
- Shared package (mips_defs):
  - md_op codes: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6.
  - Default latency constants.
- One natural sub-module, md_calc: a combinational 64-bit result generator including the div-zero and overflow cases. md_unit owns the counter, pending regs, HI/LO and stall logic.

Test Plan:
- Reset then idle: after reset=0 for 1 edge, expect hi=0, lo=0, busy=0, md_stall=0 for any d_md_use.
- MULT 0xFFFFFFFF x 0x00000002: busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU on the same operands: hi=0x00000001, lo=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2: busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2: lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
- Stall handshake: hold d_md_use=1 from the start cycle. md_stall=1 on the start cycle and all 5 busy cycles, 0 in the cycle after. A second start during busy is ignored.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 (idle): hi/lo update on the next edge and busy stays 0. Then DIV x/0: busy 10 cycles, and hi/lo still hold 0x12345678/0x9ABCDEF0.
- Reset asserted at cycle 3 of a DIV: busy=0 and hi=lo=0 after that edge, and no late update occurs in later cycles.
